// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Optional parity storage is enabled with `define DMEM_PARITY_EN.
package dmem_pkg;

    localparam int DATA_W = 16;
    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM with registered read for dmem_ctrl.
// With DMEM_PARITY_EN each word carries an even-parity bit checked on read.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              perr
);

`ifdef DMEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    logic [MEM_W-1:0] mem [2**ADDR_W];
    logic [MEM_W-1:0] wword;

`ifdef DMEM_PARITY_EN
    // Parity bit makes the stored word's total population even.
    assign wword = {^wdata, wdata};
`else
    assign wword = wdata;
`endif

    // Storage is never reset; a reset on the access edge suppresses the write.
    always_ff @(posedge clk) begin
        if (en && we && !reset) begin
            mem[addr] <= wword;
        end
    end

    // Read register only updates on a load so the output holds between loads.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr][DATA_W-1:0];
        end
    end

`ifdef DMEM_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perr <= 1'b0;
        end else if (en && !we) begin
            perr <= ^mem[addr];
        end
    end
`else
    assign perr = 1'b0;
`endif

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory responder: IDLE/WAIT/DONE sequencer in front of dmem_array.
// Parity checking is built only when DMEM_PARITY_EN is defined.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [15:0]       req_addr,
    input  logic [15:0]       req_wdata,
    input  logic              wb_adv,
    output logic              mem_busy,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              parity_err
);

    localparam logic [WAIT_W-1:0] CNT_INIT =
        (WAIT_CYC > 0) ? WAIT_W'(WAIT_CYC - 1) : '0;

    state_t              state;
    logic [WAIT_W-1:0]   cnt;
    logic                cap_we;
    logic [ADDR_W-1:0]   cap_addr;
    logic [DATA_W-1:0]   cap_wdata;

    logic                access;
    logic                acc_we;
    logic [ADDR_W-1:0]   acc_addr;
    logic [DATA_W-1:0]   acc_wdata;
    logic                ram_en;
    logic                ram_perr;
    logic                perr_sticky;
    logic                unused_addr_hi;

    // Upper address bits are deliberately ignored (address aliasing).
    assign unused_addr_hi = ^req_addr;

    assign mem_busy = ((state == IDLE) && req_valid) || (state == WAIT);

    // With zero wait cycles the access happens on the capture edge, so the
    // RAM must see the live request instead of the capture registers.
    always_comb begin
        access    = 1'b0;
        acc_we    = cap_we;
        acc_addr  = cap_addr;
        acc_wdata = cap_wdata;
        case (state)
            IDLE: begin
                access    = req_valid && (WAIT_CYC == 0);
                acc_we    = req_we;
                acc_addr  = req_addr[ADDR_W-1:0];
                acc_wdata = req_wdata;
            end
            WAIT:    access = (cnt == '0);
            default: access = 1'b0;
        endcase
    end

    assign ram_en = access && !reset;

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .en    (ram_en),
        .we    (acc_we),
        .addr  (acc_addr),
        .wdata (acc_wdata),
        .rdata (rdata),
        .perr  (ram_perr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            cap_we      <= 1'b0;
            cap_addr    <= '0;
            cap_wdata   <= '0;
            rdata_valid <= 1'b0;
            perr_sticky <= 1'b0;
        end else begin
            perr_sticky <= perr_sticky | ram_perr;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cap_we    <= req_we;
                        cap_addr  <= req_addr[ADDR_W-1:0];
                        cap_wdata <= req_wdata;
                        if (WAIT_CYC == 0) begin
                            state       <= DONE;
                            rdata_valid <= !req_we;
                        end else begin
                            cnt   <= CNT_INIT;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state       <= DONE;
                        rdata_valid <= !cap_we;
                    end else begin
                        cnt <= cnt - WAIT_W'(1);
                    end
                end
                DONE: begin
                    if (wb_adv) begin
                        state       <= IDLE;
                        rdata_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ram_perr is registered on the load edge, so OR-ing it in raises the
    // flag in the first DONE cycle; the sticky bit holds it afterwards.
    assign parity_err = perr_sticky | ram_perr;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: WAIT_CYC=2 main instance plus a WAIT_CYC=0 instance.
// The parity scenario is compiled only when DMEM_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_dmem_ctrl;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid, req_we, wb_auto, wb_man, wb_adv;
    logic [15:0] req_addr, req_wdata, rdata;
    logic        mem_busy, rdata_valid, parity_err;

    logic        z_req_valid, z_req_we, z_wb_adv;
    logic [15:0] z_req_addr, z_req_wdata, z_rdata;
    logic        z_mem_busy, z_rdata_valid, z_parity_err;

    int checks   = 0;
    int failures = 0;

    assign wb_adv   = wb_auto ? ~mem_busy : wb_man;
    assign z_wb_adv = ~z_mem_busy;

    dmem_ctrl #(.ADDR_W(8), .WAIT_CYC(2)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .wb_adv(wb_adv),
        .mem_busy(mem_busy), .rdata(rdata), .rdata_valid(rdata_valid),
        .parity_err(parity_err)
    );

    dmem_ctrl #(.ADDR_W(8), .WAIT_CYC(0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(z_req_valid), .req_we(z_req_we),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata), .wb_adv(z_wb_adv),
        .mem_busy(z_mem_busy), .rdata(z_rdata), .rdata_valid(z_rdata_valid),
        .parity_err(z_parity_err)
    );

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Presents a request and holds it until the DUT drops mem_busy (DONE).
    task automatic req_until_done(input logic we, input logic [15:0] a,
                                  input logic [15:0] d,
                                  output int busy, output int lat);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        #1;
        busy = 0; lat = 0;
        while (mem_busy && lat < 20) begin
            busy++;
            cyc();
            lat++;
        end
        req_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        #1;
        checks++; if (mem_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", mem_busy); end
        checks++; if (rdata !== 16'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0000", rdata); end
        checks++; if (rdata_valid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b exp=0", rdata_valid); end
        checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL reset_perr got=%b exp=0", parity_err); end
    endtask

    task automatic test_store_load();
        int busy, lat;
        req_until_done(1'b1, 16'h0005, 16'hBEEF, busy, lat);
        checks++; if (busy !== 3) begin failures++; $display("FAIL st_busy got=%0d exp=3", busy); end
        checks++; if (rdata_valid !== 1'b0) begin failures++; $display("FAIL st_rvalid got=%b exp=0", rdata_valid); end
        cyc();
        req_until_done(1'b0, 16'h0005, 16'h0000, busy, lat);
        checks++; if (busy !== 3) begin failures++; $display("FAIL ld_busy got=%0d exp=3", busy); end
        checks++; if (lat !== 3) begin failures++; $display("FAIL ld_latency got=%0d exp=3", lat); end
        checks++; if (rdata !== 16'hBEEF) begin failures++; $display("FAIL ld_rdata got=%h exp=beef", rdata); end
        checks++; if (rdata_valid !== 1'b1) begin failures++; $display("FAIL ld_rvalid got=%b exp=1", rdata_valid); end
        cyc();
        checks++; if (rdata_valid !== 1'b0) begin failures++; $display("FAIL idle_rvalid got=%b exp=0", rdata_valid); end
        checks++; if (rdata !== 16'hBEEF) begin failures++; $display("FAIL idle_rdata_hold got=%h exp=beef", rdata); end
    endtask

    task automatic test_addr_wrap();
        int busy, lat;
        req_until_done(1'b1, 16'h0103, 16'hA5A5, busy, lat);
        cyc();
        req_until_done(1'b0, 16'h0003, 16'h0000, busy, lat);
        checks++; if (rdata !== 16'hA5A5) begin failures++; $display("FAIL wrap_rdata got=%h exp=a5a5", rdata); end
        cyc();
    endtask

    task automatic test_stall_done();
        int busy, lat;
        req_until_done(1'b1, 16'h0020, 16'h00FF, busy, lat);
        cyc();
        wb_auto = 1'b0; wb_man = 1'b0;
        req_until_done(1'b0, 16'h0020, 16'h0000, busy, lat);
        for (int i = 0; i < 4; i++) begin
            checks++; if (dut.state !== DONE) begin failures++; $display("FAIL stall_state[%0d] got=%0d exp=%0d", i, dut.state, DONE); end
            checks++; if (rdata_valid !== 1'b1) begin failures++; $display("FAIL stall_rvalid[%0d] got=%b exp=1", i, rdata_valid); end
            checks++; if (rdata !== 16'h00FF) begin failures++; $display("FAIL stall_rdata[%0d] got=%h exp=00ff", i, rdata); end
            cyc();
        end
        wb_man = 1'b1;
        cyc();
        checks++; if (dut.state !== IDLE) begin failures++; $display("FAIL release_state got=%0d exp=%0d", dut.state, IDLE); end
        checks++; if (rdata_valid !== 1'b0) begin failures++; $display("FAIL release_rvalid got=%b exp=0", rdata_valid); end
        wb_auto = 1'b1; wb_man = 1'b0;
    endtask

    task automatic test_reset_in_wait();
        int busy, lat;
        req_until_done(1'b1, 16'h0010, 16'h0000, busy, lat);
        cyc();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0010; req_wdata = 16'h5555;
        cyc(); cyc();
        // Next edge would commit the store; reset lands on it.
        checks++; if (mem_busy !== 1'b1) begin failures++; $display("FAIL wait_busy got=%b exp=1", mem_busy); end
        reset = 1'b1; req_valid = 1'b0;
        cyc();
        reset = 1'b0;
        #1;
        checks++; if (mem_busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", mem_busy); end
        checks++; if (rdata !== 16'h0000) begin failures++; $display("FAIL abort_rdata_reset got=%h exp=0000", rdata); end
        req_until_done(1'b0, 16'h0010, 16'h0000, busy, lat);
        checks++; if (rdata !== 16'h0000) begin failures++; $display("FAIL abort_no_write got=%h exp=0000", rdata); end
        checks++; if (rdata_valid !== 1'b1) begin failures++; $display("FAIL abort_ld_rvalid got=%b exp=1", rdata_valid); end
        cyc();
    endtask

    task automatic test_wait0();
        int busy;
        z_req_valid = 1'b1; z_req_we = 1'b1; z_req_addr = 16'h007F; z_req_wdata = 16'h1234;
        #1;
        busy = 0;
        while (z_mem_busy && busy < 20) begin busy++; cyc(); end
        checks++; if (busy !== 1) begin failures++; $display("FAIL w0_st_busy got=%0d exp=1", busy); end
        z_req_valid = 1'b0;
        cyc();
        z_req_valid = 1'b1; z_req_we = 1'b0; z_req_addr = 16'h007F;
        #1;
        busy = 0;
        while (z_mem_busy && busy < 20) begin busy++; cyc(); end
        checks++; if (busy !== 1) begin failures++; $display("FAIL w0_ld_busy got=%0d exp=1", busy); end
        checks++; if (z_rdata !== 16'h1234) begin failures++; $display("FAIL w0_rdata got=%h exp=1234", z_rdata); end
        checks++; if (z_rdata_valid !== 1'b1) begin failures++; $display("FAIL w0_rvalid got=%b exp=1", z_rdata_valid); end
        z_req_valid = 1'b0;
        cyc();
        checks++; if (z_rdata_valid !== 1'b0) begin failures++; $display("FAIL w0_idle_rvalid got=%b exp=0", z_rdata_valid); end
    endtask

`ifdef DMEM_PARITY_EN
    task automatic test_parity();
        int busy, lat;
        req_until_done(1'b1, 16'h0030, 16'h0F0F, busy, lat);
        cyc();
        dut.u_array.mem[8'h30] = dut.u_array.mem[8'h30] ^ 17'h10000;
        req_until_done(1'b0, 16'h0030, 16'h0000, busy, lat);
        checks++; if (parity_err !== 1'b1) begin failures++; $display("FAIL perr_done got=%b exp=1", parity_err); end
        cyc();
        req_until_done(1'b0, 16'h0005, 16'h0000, busy, lat);
        cyc(); cyc();
        checks++; if (parity_err !== 1'b1) begin failures++; $display("FAIL perr_sticky got=%b exp=1", parity_err); end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
        checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL perr_reset got=%b exp=0", parity_err); end
    endtask
`else
    task automatic test_parity();
        checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL perr_tied got=%b exp=0", parity_err); end
        checks++; if (z_parity_err !== 1'b0) begin failures++; $display("FAIL w0_perr_tied got=%b exp=0", z_parity_err); end
    endtask
`endif

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        wb_auto = 1'b1; wb_man = 1'b0;
        z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = '0; z_req_wdata = '0;
        test_reset();
        test_store_load();
        test_addr_wrap();
        test_stall_done();
        test_reset_in_wait();
        test_wait0();
        test_parity();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory responder for the 16-bit pipelined core. Sits between the EX/MEM pipeline register (requester) and the MEM/WB pipeline register (consumer of `dataMemOut`). Accepts one load or store per instruction, models a fixed multi-cycle access, and stalls the pipeline through `mem_busy` until the access completes. Owns the word-addressed data storage.

## Interface
Parameters:
- `ADDR_W`, 8 — word-address bits used; depth = 2^ADDR_W 16-bit words.
- `WAIT_CYC`, 2 — extra access cycles, legal range 0..15.

Ports:
- `clk`  in  1  — single clock; all logic on rising edge.
- `reset`  in  1  — synchronous, active-high.
- `req_valid`  in  1  — EX/MEM holds a memory instruction.
- `req_we`  in  1  — 1 = store, 0 = load; sampled with `req_valid`.
- `req_addr`  in  16  — word address; only `[ADDR_W-1:0]` used.
- `req_wdata`  in  16  — store data.
- `wb_adv`  in  1  — the MEM/WB register captures this cycle (its write enable).
- `mem_busy`  out  1  — stall request to the hazard logic.
- `rdata`  out  16  — load data, drives `dataMemOut`.
- `rdata_valid`  out  1  — high in DONE for loads.
- `parity_err`  out  1  — sticky parity error (see Configuration).

## Operation
- States: IDLE, WAIT, DONE. All state and outputs are reset synchronously.
- Reset values: state IDLE, `rdata` 0, `rdata_valid` 0, `parity_err` 0, counter 0. Storage contents are not reset.
- IDLE, `req_valid`=1: capture `req_we`, address, and data.
  - `WAIT_CYC`>0: load counter with `WAIT_CYC-1` and go to WAIT.
  - `WAIT_CYC`=0: perform the access this edge and go to DONE.
- WAIT: decrement the counter. At count 0, perform the access and go to DONE.
- Access:
  - Store writes the captured data to `mem[addr]`; `rdata` is unchanged.
  - Load registers `mem[addr]` into `rdata`.
- DONE: `rdata_valid` = captured `~we`. Stay in DONE until `wb_adv`=1, then go to IDLE.
- `mem_busy` = (IDLE & `req_valid`) | WAIT. It is combinational and low in DONE so the pipeline can advance.
- Address wrap: upper address bits are ignored, so address `0x0100` aliases `0x0000` when `ADDR_W`=8.
- Inputs that change while in WAIT or DONE are ignored; only the captured request is used.
- A request still present in IDLE after DONE is handled as a new access. The hazard logic guarantees EX/MEM advances together with `wb_adv`.
- Reset mid-operation (WAIT) aborts the access; a store is not committed. Reset in the same cycle as the access edge wins: no write occurs.

## Timing
- Request first seen in IDLE at cycle n. DONE occurs at cycle n+1+`WAIT_CYC`.
- `mem_busy` is high for exactly `WAIT_CYC`+1 cycles per access.
- `rdata` is stable from DONE until the next load completes.
- Back-to-back accesses have a minimum of one cycle in DONE between them. Throughput is one access per `WAIT_CYC`+2 cycles.
- `wb_adv` low in DONE holds DONE indefinitely, and `rdata_valid` stays high throughout.

## Configuration
- Macro: `DMEM_PARITY_EN`.
- Defined:
  - Each word stores an extra even-parity bit, computed on store.
  - On a load, the stored parity is checked against the read word.
  - A mismatch sets `parity_err` in the DONE-entry cycle. It stays set until reset.
  - Loading a never-written location gives undefined parity.
- Undefined: no parity storage; `parity_err` is tied to 0. The port list is identical in both builds.

## Structure
- Shared package `dmem_pkg`:
  - state enum {IDLE, WAIT, DONE};
  - `DATA_W`=16;
  - `WAIT_W`=4 (counter width).
- Sub-module `dmem_array`: single-port synchronous RAM with write enable and registered read, width `DATA_W`(+1 with parity), depth 2^`ADDR_W`.
- `dmem_ctrl` holds the FSM, counter, and capture registers.

## Test plan
- Reset with `reset`=1 for 2 cycles: `mem_busy`=0 once `req_valid`=0, `rdata`=0, `rdata_valid`=0, `parity_err`=0.
- `WAIT_CYC`=2, store 0xBEEF to addr 0x05, then load 0x05 with `wb_adv` tied to ~`mem_busy`:
  - each access shows `mem_busy` high for 3 cycles;
  - the load reaches DONE 3 cycles after the request;
  - `rdata`=0xBEEF with `rdata_valid`=1.
- `WAIT_CYC`=0: load the previously stored 0x1234 at addr 0x7F → `mem_busy` high 1 cycle, DONE on the next cycle, `rdata`=0x1234.
- Address wrap, `ADDR_W`=8: store 0xA5A5 to 0x0103, load 0x0003 → `rdata`=0xA5A5.
- Stall in DONE: hold `wb_adv`=0 for 4 cycles after a load of 0x00FF → state stays DONE, `rdata_valid`=1 and `rdata`=0x00FF held, then IDLE one cycle after `wb_adv`=1.
- Reset in WAIT during a store of 0x5555 to addr 0x10, then load 0x10 → `rdata` equals the prior contents (preloaded 0x0000), not 0x5555.
- With `DMEM_PARITY_EN`: force a stored parity bit flip, then load → `parity_err` 1 from DONE entry and stays 1 until reset.
